rca_32bit: RTL and testbench

- Registered 32-bit ripple-carry adder: S/Cout = A + B + Cin, carry rippling through a chain of 1-bit full adders.
- Sum and carry-out are captured in output registers, so results appear one clock after the operands are sampled.
- Used as a datapath arithmetic leaf wherever an area-cheap, non-lookahead adder is acceptable.

---
 rtl/rca_32bit_full_adder.sv | 16 +
 rtl/rca_32bit.sv | 49 ++++
 tb/tb_rca_32bit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rca_32bit_full_adder.sv
// One-bit full adder cell; the ripple chain in rca_32bit is built from these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/rca_32bit.sv
// Registered ripple-carry adder: {Cout,S} = A + B + Cin, one cycle of latency.
module rca_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = Cin;

    // Carry ripples strictly bit by bit; no lookahead anywhere in the chain.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            full_adder u_fa (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (carry[gi]),
                .s    (sum_comb[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Result registers load only on valid cycles, so idle-cycle inputs never disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S         <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= sum_comb;
                Cout <= carry[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_rca_32bit.sv
// Self-checking bench for rca_32bit: directed boundaries, hold, back-to-back, async reset, random sweep.
module tb_rca_32bit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic [31:0] S;
    logic        Cout;
    logic        out_valid;

    int checks;
    int errors;

    rca_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b, input logic c);
        return 33'(a) + 33'(b) + 33'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [31:0] es, input logic ec, input logic ev);
        checks++;
        if (S !== es || Cout !== ec || out_valid !== ev) begin
            errors++;
            $display("FAIL %s: got S=%08h Cout=%0b out_valid=%0b, expected S=%08h Cout=%0b out_valid=%0b",
                     name, S, Cout, out_valid, es, ec, ev);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Cin = 1'b1;
        #3;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("reset_hold", 32'h0, 1'b0, 1'b0);
        end
        #2 rst_n = 1'b1;
        step();
        check_out("reset_release", 32'hFFFF_FFFF, 1'b1, 1'b1);
        $display("test_reset: S=%08h Cout=%0b out_valid=%0b", S, Cout, out_valid);
    endtask

    task automatic test_directed();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic        tc [4];
        logic [32:0] exp_v;
        ta[0] = 32'hFFFF_0000; tb[0] = 32'h0000_FFFF; tc[0] = 1'b1;
        ta[1] = 32'd2017701177; tb[1] = 32'd1701853; tc[1] = 1'b0;
        ta[2] = 32'hFFAB_CEDC; tb[2] = 32'hEF82_1EDA; tc[2] = 1'b1;
        ta[3] = 32'h0;         tb[3] = 32'h0;         tc[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; A = ta[i]; B = tb[i]; Cin = tc[i];
            exp_v = golden(ta[i], tb[i], tc[i]);
            step();
            check_out("directed", exp_v[31:0], exp_v[32], 1'b1);
            $display("test_directed: A=%08h B=%08h Cin=%0b -> S=%08h Cout=%0b", ta[i], tb[i], tc[i], S, Cout);
        end
        // spot-check the literal values from the datasheet examples
        in_valid = 1'b1; A = 32'd2017701177; B = 32'd1701853; Cin = 1'b0;
        step();
        check_out("decimal_literal", 32'h785D_A516, 1'b0, 1'b1);
        A = 32'hFFAB_CEDC; B = 32'hEF82_1EDA; Cin = 1'b1;
        step();
        check_out("carry_literal", 32'hEF2D_EDB7, 1'b1, 1'b1);
        A = 32'hFFFF_FFFF; B = 32'h0; Cin = 1'b1;
        step();
        check_out("wrap_literal", 32'h0, 1'b1, 1'b1);
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Cin = 1'b1;
        step();
        check_out("ones_literal", 32'hFFFF_FFFF, 1'b1, 1'b1);
    endtask

    task automatic test_hold();
        logic [32:0] exp_v;
        in_valid = 1'b1; A = $urandom; B = $urandom; Cin = 1'($urandom);
        exp_v = golden(A, B, Cin);
        step();
        check_out("hold_load", exp_v[31:0], exp_v[32], 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0; A = $urandom; B = $urandom; Cin = 1'($urandom);
            if (i == 2) begin A = 'x; B = 'x; Cin = 'x; end
            step();
            check_out("hold_idle", exp_v[31:0], exp_v[32], 1'b0);
            $display("test_hold: idle cycle %0d S=%08h Cout=%0b out_valid=%0b", i, S, Cout, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] q [$];
        logic [32:0] exp_v;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; A = $urandom; B = $urandom; Cin = 1'($urandom);
            q.push_back(golden(A, B, Cin));
            step();
            exp_v = q.pop_front();
            check_out("back_to_back", exp_v[31:0], exp_v[32], 1'b1);
            $display("test_back_to_back: op %0d S=%08h Cout=%0b", i, S, Cout);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Cin = 1'b1;
        step();
        check_out("pre_async", 32'hFFFF_FFFF, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_out("async_immediate", 32'h0, 1'b0, 1'b0);
        step();
        check_out("async_held", 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        A = 32'h1234_5678; B = 32'h0000_0001; Cin = 1'b0;
        step();
        check_out("async_release", 32'h1234_5679, 1'b0, 1'b1);
        $display("test_async_reset: after release S=%08h Cout=%0b out_valid=%0b", S, Cout, out_valid);
    endtask

    task automatic test_random();
        logic [32:0] exp_v;
        logic        exp_ov;
        int          err_before;
        err_before = errors;
        exp_v  = {Cout, S};
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            A = $urandom; B = $urandom; Cin = 1'($urandom);
            if (i % 97 == 0) A = 32'hFFFF_FFFF;
            exp_ov = in_valid;
            if (in_valid) exp_v = golden(A, B, Cin);
            step();
            check_out("random", exp_v[31:0], exp_v[32], exp_ov);
        end
        $display("test_random: 10000 vectors, %0d errors", errors - err_before);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
